pauli_frame_writer: RTL and testbench
=====================================

PAULI_FRAME_WRITER -- requirements
Module: pauli_frame_writer

Interface
REQ-001 Parameter NUM_QUBITS, default 49: number of tracked qubits.
REQ-002 Parameter ADDR_W, default $clog2(NUM_QUBITS): qubit address width.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 corr_valid  input  1  decoder correction available.
REQ-006 corr_ready  output  1  correction accepted when corr_valid & corr_ready.
REQ-007 corr_addr  input  ADDR_W  target qubit of correction.
REQ-008 corr_pauli  input  2  correction {Z,X}, XORed into frame.
REQ-009 trk_rd_addr  output  ADDR_W  frame-tracker async read address.
REQ-010 trk_rd_pauli  input  2  frame-tracker async read data, valid same cycle.
REQ-011 trk_wr_en  output  1  frame-tracker write strobe.
REQ-012 trk_wr_addr  output  ADDR_W  frame-tracker write address.
REQ-013 trk_wr_pauli  output  2  frame-tracker write data.
REQ-014 dump_req  input  1  single-cycle request to stream out the full frame.
REQ-015 dump_clear  input  1  sampled with dump_req; 1 = zero each entry as it is streamed.
REQ-016 dump_busy  output  1  high while in DUMP.
REQ-017 out_valid  output  1  streamed frame entry valid; out_ready  input  1  sink ready.
REQ-018 out_addr  output  ADDR_W; out_pauli  output  2; out_last  output  1  high on entry NUM_QUBITS-1.
REQ-019 upd_cnt  output  16  count of applied non-identity corrections since last dump start.
REQ-020 err_range  output  1  sticky: correction with corr_addr >= NUM_QUBITS seen; err_clr  input  1  clears it.

Function
REQ-021 FSM states IDLE, DUMP; IDLE->DUMP on dump_req in IDLE; DUMP->IDLE on handshake of entry with out_last=1.
REQ-022 IDLE: corr_ready=1; DUMP: corr_ready=0.
REQ-023 Accepted correction, in range, corr_pauli!=00: same cycle trk_rd_addr=trk_wr_addr=corr_addr, trk_wr_en=1, trk_wr_pauli=trk_rd_pauli XOR corr_pauli; zero-cycle latency, no stall.
REQ-024 Back-to-back corrections to the same address on consecutive cycles SHALL both take effect (second reads the value written by the first).
REQ-025 corr_pauli==00 accepted: trk_wr_en=0, upd_cnt unchanged.
REQ-026 corr_addr >= NUM_QUBITS accepted: trk_wr_en=0, err_range set next cycle, upd_cnt unchanged.
REQ-027 err_clr and new range error in the same cycle: err_range remains 1.
REQ-028 upd_cnt increments by 1 per applied correction, saturates at 0xFFFF, clears to 0 on IDLE->DUMP.
REQ-029 dump_req and an accepted correction in the same IDLE cycle: correction is applied; dump begins next cycle and reflects it.
REQ-030 dump_req while in DUMP is ignored; dump_clear is latched only on IDLE->DUMP.
REQ-031 DUMP: scan counter starts at 0; trk_rd_addr=out_addr=counter; out_pauli=trk_rd_pauli; out_valid=1.
REQ-032 out_valid & !out_ready: out_addr/out_pauli held stable, counter held.
REQ-033 out_valid & out_ready: counter increments; if latched dump_clear=1, trk_wr_en=1, trk_wr_addr=counter, trk_wr_pauli=00 that cycle.
REQ-034 Outside REQ-023/REQ-033 conditions trk_wr_en=0.
REQ-035 In IDLE: out_valid=0, out_last=0, dump_busy=0; trk_rd_addr=corr_addr.

Reset
REQ-036 rst_n low at any time, including mid-dump: state=IDLE, counter=0, upd_cnt=0, err_range=0, latched dump_clear=0, trk_wr_en=0, out_valid=0, out_last=0, dump_busy=0, out_addr=0, trk_wr_addr=0, trk_wr_pauli=00.
REQ-037 First correction SHALL be accepted on the first posedge after rst_n deasserts.

Verification
REQ-038 Corrections (5,X=01),(5,Z=10) on consecutive cycles, tracker initially 00 -> entry 5 = 11, upd_cnt=2.
REQ-039 Correction (60,01) with NUM_QUBITS=49 -> no trk_wr_en, err_range=1 until err_clr pulse.
REQ-040 dump_req with dump_clear=1, out_ready always 1 -> 49 entries addr 0..48 over 49 cycles, out_last on addr 48, all entries read 00 afterwards.
REQ-041 Dump with out_ready toggling 1/0 -> each addr appears exactly once, held while stalled, corr_ready=0 throughout.
REQ-042 dump_req plus correction (0,11) same cycle -> first streamed entry addr 0 = 11.
REQ-043 rst_n pulsed during dump at addr 20 -> all outputs at reset values, next correction accepted immediately.

Source files
------------

// File: rtl/pauli_frame_writer_if.sv
// Bundle of signals for the Pauli frame writer: the decoder correction
// channel, the async-read / sync-write frame-tracker port, the dump control
// inputs and the streamed frame output.
//   slave  : view taken by pauli_frame_writer
//   master : view taken by whatever drives corrections / hosts the tracker
interface pauli_frame_writer_if #(
  parameter int ADDR_W = 6
);
  // decoder correction channel
  logic              corr_valid;
  logic              corr_ready;
  logic [ADDR_W-1:0] corr_addr;
  logic [1:0]        corr_pauli;    // {Z,X}
  // frame tracker port
  logic [ADDR_W-1:0] trk_rd_addr;
  logic [1:0]        trk_rd_pauli;
  logic              trk_wr_en;
  logic [ADDR_W-1:0] trk_wr_addr;
  logic [1:0]        trk_wr_pauli;
  // dump control
  logic              dump_req;
  logic              dump_clear;
  logic              dump_busy;
  // streamed frame output
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [1:0]        out_pauli;
  logic              out_last;
  // status
  logic [15:0]       upd_cnt;
  logic              err_range;
  logic              err_clr;

  modport slave (
    input  corr_valid, corr_addr, corr_pauli, trk_rd_pauli,
           dump_req, dump_clear, out_ready, err_clr,
    output corr_ready, trk_rd_addr, trk_wr_en, trk_wr_addr, trk_wr_pauli,
           dump_busy, out_valid, out_addr, out_pauli, out_last,
           upd_cnt, err_range
  );

  modport master (
    output corr_valid, corr_addr, corr_pauli, trk_rd_pauli,
           dump_req, dump_clear, out_ready, err_clr,
    input  corr_ready, trk_rd_addr, trk_wr_en, trk_wr_addr, trk_wr_pauli,
           dump_busy, out_valid, out_addr, out_pauli, out_last,
           upd_cnt, err_range
  );
endinterface

// File: rtl/pauli_frame_writer.sv
// Pauli frame writer: applies decoder corrections to an external frame
// tracker with zero-cycle read-modify-write, and on request streams the whole
// frame out (optionally zeroing each entry as it leaves).
// Ports:
//   clk    : sole clock, posedge
//   rst_n  : asynchronous active-low reset
//   bus    : pauli_frame_writer_if.slave (correction, tracker, dump, stream,
//            update counter and sticky range error)
module pauli_frame_writer #(
  parameter int NUM_QUBITS = 49,
  parameter int ADDR_W     = $clog2(NUM_QUBITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pauli_frame_writer_if.slave     bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DUMP = 1'b1
  } state_e;

  localparam int unsigned             NUM_U    = NUM_QUBITS;
  localparam logic [ADDR_W-1:0]       LAST_IDX = ADDR_W'(NUM_QUBITS - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] scan_q;       // dump scan counter
  logic              clr_q;        // dump_clear latched at dump start
  logic              busy_q;
  logic [15:0]       upd_cnt_q;
  logic              err_q;

  logic              corr_fire_s;
  logic              in_range_s;
  logic              apply_s;
  logic              range_err_s;
  logic              out_hs_s;
  logic              dump_start_s;
  logic [15:0]       upd_cnt_d;
  logic              err_d;

  // Handshake qualifiers; the range test is done at 32 bits so that a
  // power-of-two NUM_QUBITS cannot alias to zero.
  always_comb begin
    corr_fire_s  = bus.corr_valid && (state_q == ST_IDLE);
    in_range_s   = 32'(bus.corr_addr) < NUM_U;
    apply_s      = corr_fire_s && in_range_s && (bus.corr_pauli != 2'b00);
    range_err_s  = corr_fire_s && !in_range_s;
    out_hs_s     = (state_q == ST_DUMP) && bus.out_ready;
    dump_start_s = (state_q == ST_IDLE) && bus.dump_req;
  end

  // Tracker port: combinational read-modify-write in IDLE, scan read and
  // optional zeroing write in DUMP. Writes are suppressed while in reset
  // so the strobe shows its reset value even if corr_valid is held high.
  always_comb begin
    bus.trk_rd_addr  = bus.corr_addr;
    bus.trk_wr_en    = 1'b0;
    bus.trk_wr_addr  = {ADDR_W{1'b0}};
    bus.trk_wr_pauli = 2'b00;
    if (!rst_n) begin
      bus.trk_wr_en = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (apply_s) begin
        bus.trk_wr_en    = 1'b1;
        bus.trk_wr_addr  = bus.corr_addr;
        bus.trk_wr_pauli = bus.trk_rd_pauli ^ bus.corr_pauli;
      end else begin
        bus.trk_wr_en = 1'b0;
      end
    end else begin
      bus.trk_rd_addr = scan_q;
      if (out_hs_s && clr_q) begin
        bus.trk_wr_en    = 1'b1;
        bus.trk_wr_addr  = scan_q;
        bus.trk_wr_pauli = 2'b00;
      end else begin
        bus.trk_wr_en = 1'b0;
      end
    end
  end

  // Stream and status outputs, all derived from registered state.
  always_comb begin
    bus.corr_ready = (state_q == ST_IDLE);
    bus.dump_busy  = busy_q;
    bus.out_valid  = (state_q == ST_DUMP);
    bus.out_addr   = scan_q;
    bus.out_last   = (state_q == ST_DUMP) && (scan_q == LAST_IDX);
    bus.upd_cnt    = upd_cnt_q;
    bus.err_range  = err_q;
    if (state_q == ST_DUMP) begin
      bus.out_pauli = bus.trk_rd_pauli;
    end else begin
      bus.out_pauli = 2'b00;
    end
  end

  // Dump FSM with scan counter, latched clear flag and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      scan_q  <= {ADDR_W{1'b0}};
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.dump_req) begin
            state_q <= ST_DUMP;
            scan_q  <= {ADDR_W{1'b0}};
            clr_q   <= bus.dump_clear;
            busy_q  <= 1'b1;
          end
        end
        ST_DUMP: begin
          // dump_req is ignored here; only a handshake moves the scan
          if (bus.out_ready) begin
            if (scan_q == LAST_IDX) begin
              state_q <= ST_IDLE;
              scan_q  <= {ADDR_W{1'b0}};
              clr_q   <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              scan_q <= scan_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          scan_q  <= {ADDR_W{1'b0}};
          clr_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Next values for the update counter and sticky range error. A dump start
  // clears the counter even if a correction is applied in the same cycle;
  // a new range error beats a simultaneous err_clr.
  always_comb begin
    upd_cnt_d = upd_cnt_q;
    err_d     = err_q;
    if (dump_start_s) begin
      upd_cnt_d = 16'h0000;
    end else if (apply_s && (upd_cnt_q != 16'hFFFF)) begin
      upd_cnt_d = upd_cnt_q + 16'h0001;
    end else begin
      upd_cnt_d = upd_cnt_q;
    end
    if (range_err_s) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_cnt_q <= 16'h0000;
      err_q     <= 1'b0;
    end else begin
      upd_cnt_q <= upd_cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_pauli_frame_writer.sv
// Directed bench for pauli_frame_writer: a correction vector table with
// hand-computed tracker write data, counter and error values, followed by
// hand-written dump sequences (plain, clearing, stalled, reset mid-dump).
module tb_pauli_frame_writer;
  localparam int NQ = 49;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pauli_frame_writer_if #(.ADDR_W(AW)) bus ();

  pauli_frame_writer #(.NUM_QUBITS(NQ), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Frame tracker model: async read, write on posedge.
  logic [1:0] trk_mem [0:63];
  logic       mem_init;
  assign bus.trk_rd_pauli = trk_mem[bus.trk_rd_addr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 64; k++) trk_mem[k] <= 2'b00;
    end else if (bus.trk_wr_en) begin
      trk_mem[bus.trk_wr_addr] <= bus.trk_wr_pauli;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_frame [0:NQ-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       v;
    logic [5:0] a;
    logic [1:0] p;
    logic       we;
    logic [1:0] wp;
    logic [15:0] cnt;
    logic       err;
  } vec_t;
  vec_t tbl [10];

  // Stream checker for one whole dump. toggle: out_ready alternates 1/0 and
  // a stray dump_req is pulsed mid-dump; clr: zeroing writes expected.
  task automatic stream(input bit toggle, input bit clr);
    int  exp_i;
    bit  rdy;
    exp_i = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      bus.corr_valid = 1'b0;
      bus.dump_clear = 1'b0;
      bus.dump_req   = (toggle && cyc == 3) ? 1'b1 : 1'b0;
      rdy            = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.out_ready  = rdy;
      #1;
      chk("out_valid", 32'(bus.out_valid), 32'd1);
      chk("out_addr", 32'(bus.out_addr), 32'(exp_i));
      chk("out_pauli", 32'(bus.out_pauli), 32'(exp_frame[exp_i]));
      chk("out_last", 32'(bus.out_last), 32'(exp_i == NQ - 1));
      chk("corr_ready_dump", 32'(bus.corr_ready), 32'd0);
      chk("dump_busy", 32'(bus.dump_busy), 32'd1);
      chk("dump_wr_en", 32'(bus.trk_wr_en), 32'(rdy && clr));
      if (rdy && clr) begin
        chk("dump_wr_addr", 32'(bus.trk_wr_addr), 32'(exp_i));
        chk("dump_wr_pauli", 32'(bus.trk_wr_pauli), 32'd0);
      end
      if (rdy) exp_i++;
      if (exp_i == NQ) break;
    end
    chk("dump_len", 32'(exp_i), 32'(NQ));
    @(negedge clk);
    bus.dump_req  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("dump_end_busy", 32'(bus.dump_busy), 32'd0);
    chk("dump_end_valid", 32'(bus.out_valid), 32'd0);
    chk("dump_end_ready", 32'(bus.corr_ready), 32'd1);
  endtask

  task automatic correct(input logic [5:0] a, input logic [1:0] p);
    @(negedge clk);
    bus.corr_valid = 1'b1;
    bus.corr_addr  = a;
    bus.corr_pauli = p;
    @(posedge clk);
    #1;
    bus.corr_valid = 1'b0;
  endtask

  initial begin
    int nz;
    tbl[0] = '{1'b1, 6'd5,  2'b01, 1'b1, 2'b01, 16'd1, 1'b0};
    tbl[1] = '{1'b1, 6'd5,  2'b10, 1'b1, 2'b11, 16'd2, 1'b0};
    tbl[2] = '{1'b1, 6'd7,  2'b11, 1'b1, 2'b11, 16'd3, 1'b0};
    tbl[3] = '{1'b1, 6'd7,  2'b00, 1'b0, 2'b00, 16'd3, 1'b0};
    tbl[4] = '{1'b1, 6'd7,  2'b01, 1'b1, 2'b10, 16'd4, 1'b0};
    tbl[5] = '{1'b1, 6'd60, 2'b01, 1'b0, 2'b00, 16'd4, 1'b1};
    tbl[6] = '{1'b0, 6'd3,  2'b11, 1'b0, 2'b00, 16'd4, 1'b1};
    tbl[7] = '{1'b1, 6'd48, 2'b10, 1'b1, 2'b10, 16'd5, 1'b1};
    tbl[8] = '{1'b1, 6'd49, 2'b11, 1'b0, 2'b00, 16'd5, 1'b1};
    tbl[9] = '{1'b1, 6'd2,  2'b10, 1'b1, 2'b10, 16'd6, 1'b1};

    rst_n          = 1'b0;
    mem_init       = 1'b1;
    bus.corr_valid = 1'b0;
    bus.corr_addr  = 6'd0;
    bus.corr_pauli = 2'b00;
    bus.dump_req   = 1'b0;
    bus.dump_clear = 1'b0;
    bus.out_ready  = 1'b0;
    bus.err_clr    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_dump_busy", 32'(bus.dump_busy), 32'd0);
    chk("rst_upd_cnt", 32'(bus.upd_cnt), 32'd0);
    chk("rst_err", 32'(bus.err_range), 32'd0);
    chk("rst_wr_en", 32'(bus.trk_wr_en), 32'd0);
    chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    mem_init = 1'b0;

    // correction table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.corr_valid = tbl[i].v;
      bus.corr_addr  = tbl[i].a;
      bus.corr_pauli = tbl[i].p;
      #1;
      chk("corr_ready", 32'(bus.corr_ready), 32'd1);
      chk("rd_addr", 32'(bus.trk_rd_addr), 32'(tbl[i].a));
      chk("wr_en", 32'(bus.trk_wr_en), 32'(tbl[i].we));
      if (tbl[i].we) begin
        chk("wr_addr", 32'(bus.trk_wr_addr), 32'(tbl[i].a));
        chk("wr_pauli", 32'(bus.trk_wr_pauli), 32'(tbl[i].wp));
      end
      @(posedge clk);
      #1;
      chk("upd_cnt", 32'(bus.upd_cnt), 32'(tbl[i].cnt));
      chk("err_range", 32'(bus.err_range), 32'(tbl[i].err));
    end

    // err_clr together with a new range error keeps the flag, then clears
    @(negedge clk);
    bus.corr_valid = 1'b1;
    bus.corr_addr  = 6'd60;
    bus.corr_pauli = 2'b01;
    bus.err_clr    = 1'b1;
    @(posedge clk);
    #1;
    chk("err_clr_vs_new", 32'(bus.err_range), 32'd1);
    @(negedge clk);
    bus.corr_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("err_cleared", 32'(bus.err_range), 32'd0);
    bus.err_clr = 1'b0;

    // dump 1: dump_req with correction (0,11) in the same cycle, no clear
    for (int k = 0; k < NQ; k++) exp_frame[k] = 2'b00;
    exp_frame[0] = 2'b11; exp_frame[2] = 2'b10; exp_frame[5] = 2'b11;
    exp_frame[7] = 2'b10; exp_frame[48] = 2'b10;
    @(negedge clk);
    bus.corr_valid = 1'b1;
    bus.corr_addr  = 6'd0;
    bus.corr_pauli = 2'b11;
    bus.dump_req   = 1'b1;
    bus.dump_clear = 1'b0;
    bus.out_ready  = 1'b1;
    #1;
    chk("dump_corr_wr_en", 32'(bus.trk_wr_en), 32'd1);
    chk("dump_corr_pauli", 32'(bus.trk_wr_pauli), 32'd3);
    @(posedge clk);
    #1;
    chk("dump_start_cnt", 32'(bus.upd_cnt), 32'd0);
    stream(1'b0, 1'b0);

    // dump 2: clearing dump, then tracker must be all zero
    @(negedge clk);
    bus.dump_req   = 1'b1;
    bus.dump_clear = 1'b1;
    @(posedge clk);
    stream(1'b0, 1'b1);
    nz = 0;
    for (int k = 0; k < NQ; k++) if (trk_mem[k] != 2'b00) nz++;
    chk("cleared_entries", 32'(nz), 32'd0);

    // dump 3: two fresh corrections, stalled stream
    correct(6'd10, 2'b01);
    correct(6'd11, 2'b10);
    chk("cnt_after_two", 32'(bus.upd_cnt), 32'd2);
    for (int k = 0; k < NQ; k++) exp_frame[k] = 2'b00;
    exp_frame[10] = 2'b01; exp_frame[11] = 2'b10;
    @(negedge clk);
    bus.dump_req   = 1'b1;
    bus.dump_clear = 1'b0;
    @(posedge clk);
    stream(1'b1, 1'b0);

    // dump 4: reset mid-dump at addr 20, correction accepted right after
    @(negedge clk);
    bus.dump_req  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.dump_req = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("pre_rst_addr", 32'(bus.out_addr), 32'd20);
    rst_n          = 1'b0;
    bus.corr_valid = 1'b1;
    bus.corr_addr  = 6'd9;
    bus.corr_pauli = 2'b01;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_last", 32'(bus.out_last), 32'd0);
    chk("mid_rst_busy", 32'(bus.dump_busy), 32'd0);
    chk("mid_rst_addr", 32'(bus.out_addr), 32'd0);
    chk("mid_rst_wr_en", 32'(bus.trk_wr_en), 32'd0);
    chk("mid_rst_wr_addr", 32'(bus.trk_wr_addr), 32'd0);
    chk("mid_rst_wr_pauli", 32'(bus.trk_wr_pauli), 32'd0);
    chk("mid_rst_cnt", 32'(bus.upd_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.corr_ready), 32'd1);
    chk("post_rst_wr_en", 32'(bus.trk_wr_en), 32'd1);
    chk("post_rst_wr_pauli", 32'(bus.trk_wr_pauli), 32'd1);
    @(posedge clk);
    #1;
    bus.corr_valid = 1'b0;
    chk("post_rst_cnt", 32'(bus.upd_cnt), 32'd1);
    chk("post_rst_mem", 32'(trk_mem[9]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
